// File: rtl/lrhls_div_33s_15ns_18_seq.sv
// Sequential restoring divider: 33-bit signed dividend by 15-bit unsigned divisor.
// Produces a saturated 18-bit signed quotient and a 16-bit signed remainder.
module lrhls_div_33s_15ns_18_seq #(
    parameter int unsigned DIVIDEND_WIDTH = 33,
    parameter int unsigned DIVISOR_WIDTH  = 15,
    parameter int unsigned QUOTIENT_WIDTH = 18
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic [QUOTIENT_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH:0]    rem,
    output logic                      ovf,
    output logic                      dbz
);

    localparam int unsigned CntW = $clog2(DIVIDEND_WIDTH);
    localparam int unsigned RemW = DIVISOR_WIDTH + 1;
    localparam int unsigned DW   = DIVIDEND_WIDTH;
    localparam int unsigned QW   = QUOTIENT_WIDTH;

    localparam logic [DW-1:0] PosLim = DW'((64'd1 << (QW - 1)) - 64'd1);
    localparam logic [DW-1:0] NegLim = DW'(64'd1 << (QW - 1));
    localparam logic [QW-1:0] QMax   = {1'b0, {(QW - 1){1'b1}}};
    localparam logic [QW-1:0] QMin   = {1'b1, {(QW - 1){1'b0}}};
    localparam logic [CntW-1:0] LastCnt = CntW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StCalc, StFix, StDone} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]            a_q, a_d;
    logic [DIVISOR_WIDTH-1:0] b_q, b_d;
    logic [DW-1:0]            mag_q, mag_d;
    logic [DW-1:0]            qacc_q, qacc_d;
    logic [RemW-1:0]          part_q, part_d;
    logic                     neg_q, neg_d;
    logic                     zero_q, zero_d;
    logic [QW-1:0]            quot_q, quot_d;
    logic [RemW-1:0]          rem_q, rem_d;
    logic                     ovf_q, ovf_d;
    logic                     dbz_q, dbz_d;

    logic [RemW-1:0] shifted;
    logic [RemW-1:0] diff;
    logic            ge;

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ap_start) state_d = StLoad;
            StLoad: state_d = StCalc;
            StCalc: if (cnt_q == LastCnt) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ap_idle  = (state_q == StIdle);
        ap_ready = ap_idle & ap_start;
        ap_done  = (state_q == StDone);
    end

    // Partial remainder is always below the divisor, so the shift never loses a bit.
    assign shifted = {part_q[RemW-2:0], mag_q[DW-1]};
    assign ge      = (shifted >= {1'b0, b_q});
    assign diff    = shifted - {1'b0, b_q};

    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        mag_d  = mag_q;
        qacc_d = qacc_q;
        part_d = part_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (ap_ready) begin
                    a_d = din0;
                    b_d = din1;
                end
            end
            StLoad: begin
                mag_d  = a_q[DW-1] ? (~a_q + 1'b1) : a_q;
                neg_d  = a_q[DW-1];
                zero_d = (b_q == '0);
                part_d = '0;
                qacc_d = '0;
                cnt_d  = '0;
            end
            StCalc: begin
                part_d = ge ? diff : shifted;
                qacc_d = {qacc_q[DW-2:0], ge};
                mag_d  = {mag_q[DW-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
            end
            StFix: begin
                if (zero_q) begin
                    quot_d = neg_q ? QMin : QMax;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else begin
                    dbz_d = 1'b0;
                    rem_d = neg_q ? (~part_q + 1'b1) : part_q;
                    if (!neg_q && (qacc_q > PosLim)) begin
                        quot_d = QMax;
                        ovf_d  = 1'b1;
                    end else if (neg_q && (qacc_q > NegLim)) begin
                        quot_d = QMin;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = neg_q ? (~qacc_q[QW-1:0] + 1'b1) : qacc_q[QW-1:0];
                        ovf_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mag_q  <= '0;
            qacc_q <= '0;
            part_q <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            mag_q  <= mag_d;
            qacc_q <= qacc_d;
            part_q <= part_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            ovf_q  <= ovf_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;

endmodule
